crossing_gen: RTL and testbench

Stimulus-side counterpart of the period/phase measurement block in the filter decoder. It produces a signed 32-bit sample stream that alternates between a level at or below `LIMIT` and a level above `LIMIT`, so each rising crossing appears at a programmed period and duty. It drives the threshold-crossing counter in simulation and in on-chip self-test, where it replaces the filter output at the counter input. It emits a known number of periods per burst and reports phase progress in the same 2-bit phase-count format the decoder uses.

---
 rtl/crossing_gen_pkg.sv | 45 ++++
 rtl/crossing_gen_if.sv | 26 ++
 rtl/crossing_gen_timer.sv | 26 ++
 rtl/crossing_gen.sv | 172 +++++++++++++++++
 tb/tb_crossing_gen.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/crossing_gen_pkg.sv
// Shared types and helpers for crossing_gen: FSM state encoding, level helpers, config clamp.
// CROSSING_GEN_NUL_EN adds the Nul_St burst-tail state.
package crossing_gen_pkg;

    typedef enum int unsigned {
        IDLE    = 32'd0,
        LOW_ST  = 32'd1,
        HIGH_ST = 32'd2
`ifdef CROSSING_GEN_NUL_EN
        ,
        NUL_ST  = 32'd3
`endif
    } state_t;

    typedef struct packed {
        logic [31:0] period;
        logic [31:0] duty;
    } cfg_t;

    function automatic longint hi_lvl(input int limit, input int amp);
        return longint'(limit) + longint'(amp);
    endfunction

    function automatic longint lo_lvl(input int limit, input int amp);
        return longint'(limit) - longint'(amp);
    endfunction

    // A level must fit 32-bit signed and must never look like the all-zero idle sample.
    function automatic logic lvl_ok(input longint v);
        return (v >= -64'sd2147483648) && (v <= 64'sd2147483647) && (v != 64'sd0);
    endfunction

    function automatic cfg_t clamp_cfg(input logic [31:0] period, input logic [31:0] duty);
        cfg_t c;
        c.period = (period < 32'd2) ? 32'd2 : period;
        c.duty   = (duty == 32'd0) ? 32'd1 : duty;
        if (c.duty >= c.period) begin
            c.duty = c.period - 32'd1;
        end else begin
            c.duty = c.duty;
        end
        return c;
    endfunction

endpackage

// File: rtl/crossing_gen_if.sv
// Configuration and sample-stream bundle of crossing_gen.
interface crossing_gen_if #(parameter int W_N_MAX = 8);
    logic                enable;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [W_N_MAX-1:0]  cfg_period;
    logic [W_N_MAX-1:0]  cfg_duty;
    logic [7:0]          cfg_bursts;
    logic                stop;
    logic signed [31:0]  signal_out;
    logic                out_valid;
    logic                edge_o;
    logic [1:0]          ph_cnt;
    logic                busy;
    logic                done;

    modport master (
        output enable, cfg_valid, cfg_period, cfg_duty, cfg_bursts, stop,
        input  cfg_ready, signal_out, out_valid, edge_o, ph_cnt, busy, done
    );

    modport slave (
        input  enable, cfg_valid, cfg_period, cfg_duty, cfg_bursts, stop,
        output cfg_ready, signal_out, out_valid, edge_o, ph_cnt, busy, done
    );
endinterface

// File: rtl/crossing_gen_timer.sv
// Loadable down-counter timing the low, high and null phases; zero marks the last cycle of a phase.
module crossing_gen_timer #(
    parameter int W_N_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [W_N_MAX-1:0] i_load_val,
    input  logic               i_en,
    output logic               o_zero
);
    logic [W_N_MAX-1:0] r_cnt;

    // Phase counter: load wins over decrement, saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= {W_N_MAX{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != {W_N_MAX{1'b0}})) begin
            r_cnt <= r_cnt - W_N_MAX'(1);
        end
    end

    assign o_zero = (r_cnt == {W_N_MAX{1'b0}});
endmodule

// File: rtl/crossing_gen.sv
// Threshold-crossing stimulus generator: bursts of low/high periods around LIMIT.
// Define CROSSING_GEN_NUL_EN to end each burst with two zero samples (Nul_St).
module crossing_gen
    import crossing_gen_pkg::*;
#(
    parameter int LIMIT   = -5,
    parameter int W_N_MAX = 8,
    parameter int AMP     = 1000
) (
    input  logic clk,
    input  logic reset,
    crossing_gen_if.slave bus
);
    localparam longint HI_L = hi_lvl(LIMIT, AMP);
    localparam longint LO_L = lo_lvl(LIMIT, AMP);
    localparam logic signed [31:0] HI = 32'(HI_L);
    localparam logic signed [31:0] LO = 32'(LO_L);
    localparam logic [W_N_MAX-1:0] ONE_W = W_N_MAX'(1);

    generate
        if (!lvl_ok(HI_L) || !lvl_ok(LO_L)) begin : g_bad_level
            $error("crossing_gen: LIMIT+/-AMP overflows 32-bit signed or equals zero");
        end
    endgenerate

    state_t              r_state, w_state_nxt;
    logic [W_N_MAX-1:0]  r_duty, r_high, w_duty_c, w_high_c, w_ld_val;
    logic [7:0]          r_bursts, r_pcnt, w_pcnt_nxt;
    logic signed [31:0]  r_sig, w_sig_nxt;
    logic                r_valid, w_valid_nxt, r_edge, w_edge_nxt, r_done, w_done_nxt;
    logic [1:0]          r_ph, w_ph_nxt;
    logic                w_ld, w_tmr_en, w_zero, w_latch, w_end;
    cfg_t                w_cfg;
    logic                w_unused_duty;

    crossing_gen_timer #(.W_N_MAX(W_N_MAX)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_zero)
    );

    assign w_cfg         = clamp_cfg(32'(bus.cfg_period), 32'(bus.cfg_duty));
    assign w_duty_c      = w_cfg.duty[W_N_MAX-1:0];
    assign w_high_c      = W_N_MAX'(w_cfg.period - w_cfg.duty);
    assign w_unused_duty = ^w_cfg.duty[31:W_N_MAX];
    assign w_end         = ((r_bursts != 8'd0) && ((r_pcnt + 8'd1) == r_bursts)) || bus.stop;

    // Next-state and next-output decode; outputs are computed for the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_sig_nxt   = r_sig;
        w_valid_nxt = r_valid;
        w_edge_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_ph_nxt    = r_ph;
        w_pcnt_nxt  = r_pcnt;
        w_ld        = 1'b0;
        w_ld_val    = r_duty - ONE_W;
        w_tmr_en    = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                w_sig_nxt   = 32'sd0;
                w_valid_nxt = 1'b0;
                if (bus.cfg_valid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = LOW_ST;
                    w_pcnt_nxt  = 8'd0;
                    w_ld        = 1'b1;
                    w_ld_val    = w_duty_c - ONE_W;
                    w_sig_nxt   = LO;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOW_ST: begin
                if (bus.enable && w_zero) begin
                    w_state_nxt = HIGH_ST;
                    w_ld        = 1'b1;
                    w_ld_val    = r_high - ONE_W;
                    w_sig_nxt   = HI;
                    w_edge_nxt  = 1'b1;
                end else begin
                    w_tmr_en = bus.enable;
                end
            end
            HIGH_ST: begin
                if (bus.enable && w_zero) begin
                    w_ph_nxt   = r_ph + 2'd1;
                    w_pcnt_nxt = r_pcnt + 8'd1;
                    if (w_end) begin
`ifdef CROSSING_GEN_NUL_EN
                        w_state_nxt = NUL_ST;
                        w_ld        = 1'b1;
                        w_ld_val    = ONE_W;
                        w_sig_nxt   = 32'sd0;
                        w_valid_nxt = 1'b1;
`else
                        w_state_nxt = IDLE;
                        w_sig_nxt   = 32'sd0;
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
`endif
                    end else begin
                        w_state_nxt = LOW_ST;
                        w_ld        = 1'b1;
                        w_sig_nxt   = LO;
                    end
                end else begin
                    w_tmr_en = bus.enable;
                end
            end
`ifdef CROSSING_GEN_NUL_EN
            NUL_ST: begin
                if (bus.enable && w_zero) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_tmr_en = bus.enable;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_sig_nxt   = 32'sd0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_sig    <= 32'sd0;
            r_valid  <= 1'b0;
            r_edge   <= 1'b0;
            r_done   <= 1'b0;
            r_ph     <= 2'd0;
            r_pcnt   <= 8'd0;
            r_duty   <= ONE_W;
            r_high   <= ONE_W;
            r_bursts <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sig   <= w_sig_nxt;
            r_valid <= w_valid_nxt;
            r_edge  <= w_edge_nxt;
            r_done  <= w_done_nxt;
            r_ph    <= w_ph_nxt;
            r_pcnt  <= w_pcnt_nxt;
            if (w_latch) begin
                r_duty   <= w_duty_c;
                r_high   <= w_high_c;
                r_bursts <= bus.cfg_bursts;
            end
        end
    end

    assign bus.signal_out = r_sig;
    assign bus.out_valid  = r_valid;
    assign bus.edge_o     = r_edge;
    assign bus.done       = r_done;
    assign bus.ph_cnt     = r_ph;
    assign bus.cfg_ready  = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_crossing_gen.sv
// Directed bench for crossing_gen (LIMIT=-5, AMP=1000: low=-1005, high=995).
module tb_crossing_gen;
    localparam logic signed [31:0] LO = -32'sd1005;
    localparam logic signed [31:0] HI = 32'sd995;

    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    crossing_gen_if #(.W_N_MAX(8)) bus ();

    crossing_gen #(.LIMIT(-5), .W_N_MAX(8), .AMP(1000)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.cfg_valid  = 1'b0;
        bus.stop       = 1'b0;
        bus.enable     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic handshake(input logic [7:0] p, input logic [7:0] d, input logic [7:0] b, input bit hold);
        bus.cfg_period = p;
        bus.cfg_duty   = d;
        bus.cfg_bursts = b;
        bus.cfg_valid  = 1'b1;
        chk("hs.ready", 32'(bus.cfg_ready), 32'sd1);
        step();
        if (hold) begin
            bus.cfg_period = 8'd10;
            bus.cfg_duty   = 8'd4;
        end else begin
            bus.cfg_valid = 1'b0;
        end
    endtask

    // Checks a whole burst starting in the first low-sample cycle.
    task automatic expect_burst(input string tag, input int lo_n, input int hi_n, input int periods,
                                input int stop_at);
        int per;
        int total;
        int pos;
        per   = lo_n + hi_n;
        total = per * periods;
        for (int c = 0; c < total; c++) begin
            pos = c % per;
            chk({tag, ".sig"},   bus.signal_out, (pos < lo_n) ? LO : HI);
            chk({tag, ".edge"},  32'(bus.edge_o), (pos == lo_n) ? 32'sd1 : 32'sd0);
            chk({tag, ".valid"}, 32'(bus.out_valid), 32'sd1);
            if (c == stop_at) bus.stop = 1'b1;
            if (c == total - 1) bus.cfg_valid = 1'b0;
            step();
        end
`ifdef CROSSING_GEN_NUL_EN
        for (int z = 0; z < 2; z++) begin
            chk({tag, ".nul_sig"},   bus.signal_out, 32'sd0);
            chk({tag, ".nul_valid"}, 32'(bus.out_valid), 32'sd1);
            chk({tag, ".nul_done"},  32'(bus.done), 32'sd0);
            step();
        end
`endif
        chk({tag, ".done"},      32'(bus.done), 32'sd1);
        chk({tag, ".end_valid"}, 32'(bus.out_valid), 32'sd0);
        chk({tag, ".end_sig"},   bus.signal_out, 32'sd0);
        chk({tag, ".end_busy"},  32'(bus.busy), 32'sd0);
        chk({tag, ".ph"},        32'(bus.ph_cnt), 32'(periods % 4));
        bus.stop = 1'b0;
        step();
        chk({tag, ".done_once"}, 32'(bus.done), 32'sd0);
    endtask

    initial begin
        bus.enable     = 1'b1;
        bus.cfg_valid  = 1'b0;
        bus.cfg_period = 8'd0;
        bus.cfg_duty   = 8'd0;
        bus.cfg_bursts = 8'd0;
        bus.stop       = 1'b0;
        do_reset();

        chk("rst.sig",   bus.signal_out, 32'sd0);
        chk("rst.valid", 32'(bus.out_valid), 32'sd0);
        chk("rst.edge",  32'(bus.edge_o), 32'sd0);
        chk("rst.done",  32'(bus.done), 32'sd0);
        chk("rst.busy",  32'(bus.busy), 32'sd0);
        chk("rst.ph",    32'(bus.ph_cnt), 32'sd0);
        chk("rst.ready", 32'(bus.cfg_ready), 32'sd1);

        // 10/4 x3: edges at cycles 5, 15, 25 after the handshake
        handshake(8'd10, 8'd4, 8'd3, 1'b0);
        chk("p10.busy",  32'(bus.busy), 32'sd1);
        chk("p10.ready", 32'(bus.cfg_ready), 32'sd0);
        expect_burst("p10", 4, 6, 3, -1);

        // 1/0 clamps to 2/1; cfg_valid held high during the burst must be ignored
        do_reset();
        handshake(8'd1, 8'd0, 8'd3, 1'b1);
        expect_burst("alt", 1, 1, 3, -1);

        // 8/9 clamps duty to 7
        do_reset();
        handshake(8'd8, 8'd9, 8'd1, 1'b0);
        expect_burst("d9", 7, 1, 1, -1);

        // free-run 4/2, stop raised in period 2's low phase
        do_reset();
        handshake(8'd4, 8'd2, 8'd0, 1'b0);
        expect_burst("stp", 2, 2, 2, 5);

        // enable low for 5 cycles on the first high sample of 4/2
        do_reset();
        handshake(8'd4, 8'd2, 8'd1, 1'b0);
        chk("en.lo0", bus.signal_out, LO);
        step();
        chk("en.lo1", bus.signal_out, LO);
        step();
        chk("en.hi0",   bus.signal_out, HI);
        chk("en.edge0", 32'(bus.edge_o), 32'sd1);
        bus.enable = 1'b0;
        for (int f = 0; f < 5; f++) begin
            step();
            chk("en.frz_sig",  bus.signal_out, HI);
            chk("en.frz_edge", 32'(bus.edge_o), 32'sd0);
            chk("en.frz_done", 32'(bus.done), 32'sd0);
        end
        bus.enable = 1'b1;
        step();
        chk("en.hi1",   bus.signal_out, HI);
        chk("en.edge1", 32'(bus.edge_o), 32'sd0);
        step();
`ifdef CROSSING_GEN_NUL_EN
        step();
        step();
`endif
        chk("en.done", 32'(bus.done), 32'sd1);
        chk("en.ph",   32'(bus.ph_cnt), 32'sd1);

        // asynchronous reset in the middle of a free-running burst
        do_reset();
        handshake(8'd10, 8'd4, 8'd0, 1'b0);
        repeat (12) step();
        chk("ar.pre_ph",  32'(bus.ph_cnt), 32'sd1);
        chk("ar.pre_sig", bus.signal_out, LO);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.sig",   bus.signal_out, 32'sd0);
        chk("ar.valid", 32'(bus.out_valid), 32'sd0);
        chk("ar.busy",  32'(bus.busy), 32'sd0);
        chk("ar.ph",    32'(bus.ph_cnt), 32'sd0);
        chk("ar.edge",  32'(bus.edge_o), 32'sd0);
        chk("ar.done",  32'(bus.done), 32'sd0);
        step();
        reset = 1'b0;
        step();
        chk("ar.ready",      32'(bus.cfg_ready), 32'sd1);
        chk("ar.post_valid", 32'(bus.out_valid), 32'sd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
